// File: rtl/auth_cmd_tx.sv
// rtl/auth_cmd_tx.sv - UART 8N1 transmitter for the 'g'/'s' power commands with one-deep pending request
module auth_cmd_tx #(
  parameter int BAUD_DIV = 2604,
  parameter int CNT_W    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_req,
  input  logic       stop_req,
  output logic       TX,
  output logic       busy,
  output logic       tx_done,
  output logic [7:0] last_cmd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [7:0]       CMD_GO    = 8'h67;
  localparam logic [7:0]       CMD_STOP  = 8'h73;

  logic [1:0]       state_q, state_d;
  logic [9:0]       shreg_q, shreg_d;   // bit 0 is the line; shifts in ones so idle is high
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       last_q, last_d;
  logic [7:0]       cur_q, cur_d;       // byte of the frame in flight
  logic             pend_v_q, pend_v_d;
  logic [7:0]       pend_b_q, pend_b_d;

  logic       req_v;
  logic [7:0] req_b;
  logic       keep_pend;
  logic       merged_v;
  logic [7:0] merged_b;
  logic       bit_end;
  logic       launch;
  logic [7:0] launch_b;

  // Next-state logic: request arbitration, bit timing, shifting and frame chaining
  always_comb begin
    req_v     = go_req | stop_req;
    req_b     = stop_req ? CMD_STOP : CMD_GO;
    // A queued power-down must survive a later power-up request.
    keep_pend = pend_v_q && (pend_b_q == CMD_STOP) && (req_b == CMD_GO);
    if (req_v && !keep_pend) begin
      merged_v = 1'b1;
      merged_b = req_b;
    end else begin
      merged_v = pend_v_q;
      merged_b = pend_b_q;
    end
    bit_end  = (baud_q == '0);

    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    cur_d    = cur_q;
    pend_v_d = pend_v_q;
    pend_b_d = pend_b_q;
    launch   = 1'b0;
    launch_b = CMD_GO;
    baud_d   = (state_q != S_IDLE && !bit_end) ? baud_q - 1'b1 : baud_q;

    if (state_q != S_IDLE) begin
      pend_v_d = merged_v;
      pend_b_d = merged_b;
    end

    case (state_q)
      S_IDLE: begin
        if (req_v) begin
          launch   = 1'b1;
          launch_b = req_b;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          shreg_d = {1'b1, shreg_q[9:1]};
          baud_d  = BAUD_LAST;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = {1'b1, shreg_q[9:1]};
          baud_d  = BAUD_LAST;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        // End of stop bit: chain straight into the next frame if one is waiting.
        if (bit_end) begin
          if (merged_v) begin
            launch   = 1'b1;
            launch_b = merged_b;
            pend_v_d = 1'b0;
          end else begin
            state_d = S_IDLE;
            shreg_d = '1;
          end
        end
      end
    endcase

    if (launch) begin
      state_d = S_START;
      shreg_d = {1'b1, launch_b, 1'b0};
      baud_d  = BAUD_LAST;
      bit_d   = 3'd0;
      cur_d   = launch_b;
    end

    done_d = (state_d == S_STOP) && (baud_d == '0);
    last_d = done_d ? cur_q : last_q;
    busy_d = (state_d != S_IDLE) || pend_v_d;
  end

  // State registers with synchronous reset; reset aborts any frame and drops requests
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 8'h00;
      cur_q    <= 8'h00;
      pend_v_q <= 1'b0;
      pend_b_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      last_q   <= last_d;
      cur_q    <= cur_d;
      pend_v_q <= pend_v_d;
      pend_b_q <= pend_b_d;
    end
  end

  assign TX       = shreg_q[0];
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign last_cmd = last_q;

endmodule

// File: tb/tb_auth_cmd_tx.sv
// tb/tb_auth_cmd_tx.sv - self-checking bench for auth_cmd_tx with frame model and loopback receiver
module tb_auth_cmd_tx;

  localparam int BD    = 4;
  localparam int FRAME = 10 * BD;
  localparam logic [9:0] FRAME_G = 10'b1_0110_0111_0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go_req = 1'b0;
  logic       stop_req = 1'b0;
  logic       TX;
  logic       busy;
  logic       tx_done;
  logic [7:0] last_cmd;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  auth_cmd_tx #(.BAUD_DIV(BD), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .go_req(go_req), .stop_req(stop_req),
    .TX(TX), .busy(busy), .tx_done(tx_done), .last_cmd(last_cmd)
  );

  always #5 clk = ~clk;

  // Frame-level model: position within the current frame plus a one-deep request slot
  bit         m_act = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_pv = 1'b0;
  logic [7:0] m_pb = 8'h00;
  logic [7:0] m_last = 8'h00;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    logic       rv;
    logic [7:0] rb;
    if (rst) begin
      m_act = 1'b0; m_pv = 1'b0; m_last = 8'h00; m_pos = 0;
      rx_q.delete();
    end else begin
      rv = go_req | stop_req;
      rb = stop_req ? 8'h73 : 8'h67;
      if (!m_act) begin
        if (rv) begin m_act = 1'b1; m_pos = 0; m_byte = rb; end
      end else begin
        if (rv && !(m_pv && m_pb == 8'h73 && rb == 8'h67)) begin m_pv = 1'b1; m_pb = rb; end
        if (m_pos == FRAME - 1) begin
          if (m_pv) begin m_pos = 0; m_byte = m_pb; m_pv = 1'b0; end
          else m_act = 1'b0;
        end else begin
          m_pos++;
        end
      end
      if (m_act && m_pos == FRAME - 1) m_last = m_byte;
    end
  end

  function automatic logic exp_tx();
    if (!m_act) return 1'b1;
    if (m_pos < BD) return 1'b0;
    if (m_pos < 9 * BD) return m_byte[(m_pos - BD) / BD];
    return 1'b1;
  endfunction

  // Loopback receiver sampling mid-bit
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (TX == 1'b0) begin rx_busy = 1'b1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt == BD / 2) begin
        checks++;
        if (TX !== 1'b0) begin failures++; $display("FAIL rx_start got=%b want=0", TX); rx_busy = 1'b0; end
      end else if (rx_cnt > BD / 2 && rx_cnt < BD / 2 + 9 * BD && (rx_cnt - BD / 2) % BD == 0) begin
        rx_sh = {TX, rx_sh[7:1]};
      end else if (rx_cnt == BD / 2 + 9 * BD) begin
        checks++;
        if (TX !== 1'b1) begin failures++; $display("FAIL rx_stop got=%b want=1", TX); end
        rx_q.push_back(rx_sh);
        rx_busy = 1'b0;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    logic e_tx, e_busy, e_done;
    if (chk_en) begin
      e_tx   = exp_tx();
      e_busy = m_act || m_pv;
      e_done = m_act && (m_pos == FRAME - 1);
      checks++;
      if (TX !== e_tx || busy !== e_busy || tx_done !== e_done || last_cmd !== m_last) begin
        failures++;
        $display("FAIL cycle t=%0t got tx=%b busy=%b done=%b last=%h want tx=%b busy=%b done=%b last=%h",
                 $time, TX, busy, tx_done, last_cmd, e_tx, e_busy, e_done, m_last);
      end
      if (e_done) begin
        checks++;
        if (rx_q.size() == 0) begin
          failures++;
          $display("FAIL rx_byte got=none want=%h", m_byte);
        end else begin
          logic [7:0] rb;
          rb = rx_q.pop_front();
          if (rb !== m_byte) begin failures++; $display("FAIL rx_byte got=%h want=%h", rb, m_byte); end
        end
      end
    end
  end

  task automatic step(input logic g, input logic s, input logic r);
    @(negedge clk);
    #1;
    go_req = g; stop_req = s; rst = r;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Idle-input watch: counts tx_done pulses, first/last pulse cycle, first busy-low cycle
  task automatic watch(input int n, output int nd, output int t_first, output int t_last, output int t_idle);
    nd = 0; t_first = -1; t_last = -1; t_idle = -1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        nd++;
        if (t_first < 0) t_first = c;
        t_last = c;
      end
      if (busy === 1'b0 && t_idle < 0) t_idle = c;
      #1;
      go_req = 1'b0; stop_req = 1'b0; rst = 1'b0;
    end
  endtask

  initial begin
    logic [FRAME-1:0] cap, dcap, exp_cap;
    int nd, tf, tl, ti;

    repeat (3) step(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_tx", TX, 1);
    check("reset_busy", busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_last", last_cmd, 8'h00);
    #1 rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Single 'g' frame, captured bit by bit
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      cap[i] = TX;
      dcap[i] = tx_done;
      exp_cap[i] = FRAME_G[i / BD];
      #1 go_req = 1'b0;
    end
    check("g_frame_bits", cap, exp_cap);
    check("g_done_pos", dcap, 40'h80_0000_0000);
    check("g_last", last_cmd, 8'h67);
    repeat (5) step(1'b0, 1'b0, 1'b0);

    // Simultaneous go and stop: one 's' frame only
    step(1'b1, 1'b1, 1'b0);
    watch(100, nd, tf, tl, ti);
    check("both_ndone", nd, 1);
    check("both_last", last_cmd, 8'h73);

    // stop during a 'g' frame chains back to back
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    watch(110, nd, tf, tl, ti);
    check("chain_ndone", nd, 2);
    check("chain_gap", tl - tf, FRAME);
    check("chain_busy_low", ti, tl + 1);
    check("chain_last", last_cmd, 8'h73);

    // pending 's' is not replaced by a later 'g'
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    watch(130, nd, tf, tl, ti);
    check("keep_s_ndone", nd, 2);
    check("keep_s_gap", tl - tf, FRAME);
    check("keep_s_last", last_cmd, 8'h73);

    // reset during data bit 3 aborts the frame
    step(1'b1, 1'b0, 1'b0);
    repeat (16) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("abort_tx", TX, 1);
    check("abort_busy", busy, 0);
    check("abort_last", last_cmd, 8'h00);
    #1 rst = 1'b0;
    watch(60, nd, tf, tl, ti);
    check("abort_ndone", nd, 0);
    step(1'b1, 1'b0, 1'b0);
    watch(50, nd, tf, tl, ti);
    check("after_abort_ndone", nd, 1);
    check("after_abort_last", last_cmd, 8'h67);

    // Randomized request traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      step((r < 3) || (r == 6), ((r >= 3) && (r < 5)) || (r == 6), 1'b0);
    end
    repeat (2 * FRAME + 10) step(1'b0, 1'b0, 1'b0);
    check("final_idle_busy", busy, 0);
    check("rx_queue_drained", rx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
